// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and op-class helpers for seq_alu
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_SLL   = 4'h3;
    localparam logic [3:0] OP_SRL   = 4'h4;
    localparam logic [3:0] OP_LUI   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_SLT   = 4'h9;
    localparam logic [3:0] OP_SLTU  = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_MULHU = 4'hC;
    localparam logic [3:0] OP_DIVU  = 4'hD;
    localparam logic [3:0] OP_REMU  = 4'hE;
    localparam logic [3:0] OP_RSVD  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - iterative shift-add multiply / restoring divide datapath
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             hi_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    // acc_q holds {high product, multiplier} for MUL and {remainder, quotient} for DIV
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, div_q, hi_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;

    // One iteration step; a zero divisor never borrows, which yields quotient all-ones
    // and leaves the dividend shifted back into the remainder, so no special case is needed
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        if (div_q) begin
            acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign done_o   = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign result_o = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

    // Load operands on start, then run WIDTH iterations
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            hi_q   <= 1'b0;
        end else if (start_i) begin
            acc_q  <= {{WIDTH{1'b0}}, a_i};
            b_q    <= b_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            div_q  <= div_i;
            hi_q   <= hi_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with single-cycle ops and iterative mul/div
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Ready_o,
    output logic             Valid_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    state_e           state_q, state_d;
    logic             accept, mul_op, div_op;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, valid_q;

    assign accept = Valid_i && Ready_o;
    assign mul_op = is_mul_op(ALU_Operation_i);
    assign div_op = is_div_op(ALU_Operation_i);
    assign shamt  = B_i[SHW-1:0];

    // Single-cycle result; iterative and reserved opcodes produce 0 here
    always_comb begin
        alu_res = '0;
        case (ALU_Operation_i)
            OP_ADD:  alu_res = A_i + B_i;
            OP_SUB:  alu_res = A_i - B_i;
            OP_OR:   alu_res = A_i | B_i;
            OP_SLL:  alu_res = A_i << shamt;
            OP_SRL:  alu_res = A_i >> shamt;
            OP_LUI:  alu_res = {B_i[WIDTH-13:0], 12'b0};
            OP_AND:  alu_res = A_i & B_i;
            OP_XOR:  alu_res = A_i ^ B_i;
            OP_SRA:  alu_res = $signed(A_i) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A_i < B_i)};
            default: alu_res = '0;
        endcase
    end

    seq_alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept && (mul_op || div_op)),
        .div_i   (div_op),
        .hi_i    ((ALU_Operation_i == OP_MULHU) || (ALU_Operation_i == OP_REMU)),
        .a_i     (A_i),
        .b_i     (B_i),
        .done_o  (iter_done),
        .result_o(iter_result)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: leave IDLE on an accepted iterative op, return when it finishes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && mul_op)      state_d = ST_MUL;
                else if (accept && div_op) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (iter_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the unit is ready only in IDLE and never while reset is held
    always_comb begin
        Ready_o = (state_q == ST_IDLE) && !reset;
    end

    // Register the result and pulse Valid_o once per completed op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept && !mul_op && !div_op) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                valid_q  <= 1'b1;
            end else if (iter_done) begin
                result_q <= iter_result;
                zero_q   <= (iter_result == '0);
                valid_q  <= 1'b1;
            end
        end
    end

    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;
    assign Valid_o      = valid_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             Valid_i;
    logic [3:0]       ALU_Operation_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             Ready_o;
    logic             Valid_o;
    logic [WIDTH-1:0] ALU_Result_o;
    logic             Zero_o;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .Valid_i        (Valid_i),
        .ALU_Operation_i(ALU_Operation_i),
        .A_i            (A_i),
        .B_i            (B_i),
        .Ready_o        (Ready_o),
        .Valid_o        (Valid_o),
        .ALU_Result_o   (ALU_Result_o),
        .Zero_o         (Zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; Valid_i = 1'b0; ALU_Operation_i = 4'h0; A_i = '0; B_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_held: got %b expected 0", Ready_o); end
        checks++;
        if (Valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Valid_o); end
        checks++;
        if (ALU_Result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", ALU_Result_o); end
        checks++;
        if (Zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", Zero_o); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (Ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b expected 1", Ready_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        Valid_i = 1'b1; ALU_Operation_i = 4'h0; A_i = 32'd7; B_i = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        checks++;
        if (ALU_Result_o !== 32'd4 || Zero_o !== 1'b0 || Valid_o !== 1'b1 || Ready_o !== 1'b1) begin
            errors++;
            $display("FAIL add_7_m3: got res=%h z=%b v=%b r=%b expected res=4 z=0 v=1 r=1", ALU_Result_o, Zero_o, Valid_o, Ready_o);
        end
        @(negedge clk);
        ALU_Operation_i = 4'h1; A_i = 32'd5; B_i = 32'd5;
        @(posedge clk); #1;
        checks++;
        if (ALU_Result_o !== 32'd0 || Zero_o !== 1'b1 || Valid_o !== 1'b1 || Ready_o !== 1'b1) begin
            errors++;
            $display("FAIL sub_5_5: got res=%h z=%b v=%b r=%b expected res=0 z=1 v=1 r=1", ALU_Result_o, Zero_o, Valid_o, Ready_o);
        end
        @(negedge clk);
        Valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (Valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", Valid_o); end
    endtask

    task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input string name);
        @(negedge clk);
        Valid_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
        @(posedge clk); #1;
        checks++;
        if (ALU_Result_o !== exp || Zero_o !== (exp == 32'h0) || Valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: got res=%h z=%b v=%b expected res=%h z=%b v=1", name, ALU_Result_o, Zero_o, Valid_o, exp, (exp == 32'h0));
        end
        @(negedge clk);
        Valid_i = 1'b0;
    endtask

    task automatic test_single_ops();
        run_single(4'h8, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra_b24");
        run_single(4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_m1_1");
        run_single(4'hA, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu_m1_1");
        run_single(4'h5, 32'hDEAD_BEEF, 32'h0001_2345, 32'h1234_5000, "lui");
        run_single(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, "reserved");
        run_single(4'h3, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, "sll_4");
        run_single(4'h4, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, "srl_31");
        run_single(4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
        run_single(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap");
    endtask

    task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input string name);
        int n;
        int ready_bad;
        @(negedge clk);
        Valid_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
        @(posedge clk); #1;
        Valid_i = 1'b0;
        checks++;
        if (Ready_o !== 1'b0 || Valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: got ready=%b valid=%b expected ready=0 valid=0", name, Ready_o, Valid_o);
        end
        n = 0;
        ready_bad = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (Valid_o === 1'b1) break;
            if (Ready_o !== 1'b0) ready_bad++;
            // Issue attempts while busy must be ignored
            if (n >= 4 && n <= 6) begin
                Valid_i = 1'b1; ALU_Operation_i = 4'h0; A_i = 32'd1; B_i = 32'd1;
            end else begin
                Valid_i = 1'b0;
            end
        end
        Valid_i = 1'b0;
        checks++;
        if (n !== 32) begin errors++; $display("FAIL %s_latency: got %0d expected 32", name, n); end
        checks++;
        if (ready_bad !== 0) begin errors++; $display("FAIL %s_ready_busy: got %0d ready cycles expected 0", name, ready_bad); end
        checks++;
        if (ALU_Result_o !== exp || Zero_o !== (exp == 32'h0) || Ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: got res=%h z=%b r=%b expected res=%h z=%b r=1", name, ALU_Result_o, Zero_o, Ready_o, exp, (exp == 32'h0));
        end
        @(posedge clk); #1;
        checks++;
        if (Valid_o !== 1'b0 || ALU_Result_o !== exp) begin
            errors++;
            $display("FAIL %s_single_pulse: got v=%b res=%h expected v=0 res=%h", name, Valid_o, ALU_Result_o, exp);
        end
    endtask

    task automatic test_mul();
        run_multi(4'hB, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul");
        run_multi(4'hC, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "mulhu");
    endtask

    task automatic test_div();
        run_multi(4'hD, 32'd100, 32'd7, 32'd14, "divu");
        run_multi(4'hE, 32'd100, 32'd7, 32'd2, "remu");
        run_multi(4'hD, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run_multi(4'hE, 32'd9, 32'd0, 32'd9, "remu_by0");
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        Valid_i = 1'b1; ALU_Operation_i = 4'hD; A_i = 32'd100; B_i = 32'd7;
        @(posedge clk); #1;
        Valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ALU_Result_o !== 32'h0 || Zero_o !== 1'b1 || Valid_o !== 1'b0 || Ready_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: got res=%h z=%b v=%b r=%b expected res=0 z=1 v=0 r=0", ALU_Result_o, Zero_o, Valid_o, Ready_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (Ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", Ready_o); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Valid_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
        run_single(4'h6, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, "and_after_abort");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_ops();
        test_mul();
        test_div();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
